// File: rtl/ifmap_repack_pkg.sv
// Shared constants, sideband type and segment-length helpers for the ifmap row repacker.
// Geometry is set here; the top and buffer pick it up through the package import.
package ifmap_repack_pkg;

  localparam int ELEM_W    = 8;
  localparam int IN_ELEMS  = 8;
  localparam int BUF_WORDS = 2;
  localparam int SEG_AW    = 3;
  localparam int ROW_CW    = 5;

  localparam int WORD_W        = ELEM_W * IN_ELEMS;
  localparam int BUF_ELEMS     = IN_ELEMS * BUF_WORDS;
  localparam int SEGLEN_W      = $clog2(IN_ELEMS) + 1;
  localparam int LVL_W         = $clog2(BUF_ELEMS + 1);
  localparam int ROWEL_W       = SEG_AW + $clog2(IN_ELEMS) + 1;
  localparam int MAX_ROW_ELEMS = IN_ELEMS * (2 ** SEG_AW);

  typedef struct packed {
    logic [SEG_AW-1:0]   seg_addr;
    logic [SEGLEN_W-1:0] seg_elems;
    logic [ROW_CW-1:0]   row_idx;
    logic                row_last;
    logic                tile_last;
  } sideband_t;

  // Elements of the row not yet covered by segments before seg_addr.
  function automatic logic [ROWEL_W-1:0] seg_rem(input logic [ROWEL_W-1:0] row_elems,
                                                 input logic [SEG_AW-1:0]  seg_addr);
    return row_elems - ROWEL_W'(seg_addr) * ROWEL_W'(IN_ELEMS);
  endfunction

  function automatic logic [SEGLEN_W-1:0] seg_len(input logic [ROWEL_W-1:0] row_elems,
                                                  input logic [SEG_AW-1:0]  seg_addr);
    logic [ROWEL_W-1:0] rem;
    rem = seg_rem(row_elems, seg_addr);
    if (rem >= ROWEL_W'(IN_ELEMS)) return SEGLEN_W'(IN_ELEMS);
    return rem[SEGLEN_W-1:0];
  endfunction

endpackage

// File: rtl/repack_shift_buf.sv
// Element buffer for the repacker: words append at the fill level, segments leave from element 0.
// A push landing in the same cycle as a pop is written just past the post-pop contents.
module repack_shift_buf
  import ifmap_repack_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [WORD_W-1:0]   push_data,
  input  logic                pop,
  input  logic [SEGLEN_W-1:0] pop_elems,
  output logic [LVL_W-1:0]    level,
  output logic                room,
  output logic [WORD_W-1:0]   head
);

  localparam int BUF_W = BUF_ELEMS * ELEM_W;

  logic [BUF_W-1:0] buf_q;
  logic [BUF_W-1:0] buf_d;
  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] ins_data;
  logic [BUF_W-1:0] ins_mask;
  logic [LVL_W-1:0] base;
  logic [LVL_W-1:0] level_d;

  always_comb begin
    shifted  = pop ? (buf_q >> (32'(pop_elems) * ELEM_W)) : buf_q;
    base     = level - (pop ? LVL_W'(pop_elems) : '0);
    ins_data = BUF_W'(push_data) << (32'(base) * ELEM_W);
    ins_mask = {{(BUF_W - WORD_W){1'b0}}, {WORD_W{1'b1}}} << (32'(base) * ELEM_W);
    buf_d    = push ? ((shifted & ~ins_mask) | ins_data) : shifted;
    level_d  = base + (push ? LVL_W'(IN_ELEMS) : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      level <= '0;
    end else begin
      buf_q <= buf_d;
      level <= level_d;
    end
  end

  // Room for a whole word, judged on the registered level only.
  assign room = (level <= LVL_W'(BUF_ELEMS - IN_ELEMS));
  assign head = buf_q[WORD_W-1:0];

endmodule

// File: rtl/ifmap_row_repacker.sv
// DRAM-to-row-RF repacker: slices the word stream into per-row segments with row/tile sideband.
// Define REPACK_ZERO_PAD_EN to force lanes beyond out_seg_elems to zero in out_data.
module ifmap_row_repacker
  import ifmap_repack_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_load,
  input  logic [ROWEL_W-1:0]  cfg_row_elems,
  input  logic [ROW_CW-1:0]   cfg_rows,
  output logic                cfg_err,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic [SEG_AW-1:0]   out_seg_addr,
  output logic [SEGLEN_W-1:0] out_seg_elems,
  output logic [ROW_CW-1:0]   out_row_idx,
  output logic                out_row_last,
  output logic                out_tile_last
);

  logic [ROWEL_W-1:0]  row_elems_q;
  logic [ROW_CW-1:0]   rows_q;
  logic [SEG_AW-1:0]   seg_addr_q;
  logic [ROW_CW-1:0]   row_idx_q;
  logic [LVL_W-1:0]    level;
  logic [WORD_W-1:0]   head;
  logic [WORD_W-1:0]   data_d;
  logic [WORD_W-1:0]   data_q;
  logic [SEGLEN_W-1:0] cur_len;
  sideband_t           sb_d;
  sideband_t           sb_q;
  logic                push;
  logic                pop;
  logic                idle;
  logic                cfg_bad;
  logic                row_last;
  logic                tile_last;

  assign cur_len   = seg_len(row_elems_q, seg_addr_q);
  assign row_last  = (seg_rem(row_elems_q, seg_addr_q) <= ROWEL_W'(IN_ELEMS));
  assign tile_last = row_last && (row_idx_q == rows_q - ROW_CW'(1));
  assign push      = in_valid && in_ready;
  assign pop       = (level >= LVL_W'(cur_len)) && (!out_valid || out_ready);
  assign idle      = (level == '0) && !out_valid && (seg_addr_q == '0) && (row_idx_q == '0);
  assign cfg_bad   = (cfg_row_elems == '0) || (cfg_row_elems > ROWEL_W'(MAX_ROW_ELEMS))
                     || (cfg_rows == '0);

  repack_shift_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_elems (cur_len),
    .level     (level),
    .room      (in_ready),
    .head      (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_elems_q <= ROWEL_W'(IN_ELEMS * 4 - 2);
      rows_q      <= ROW_CW'(16);
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_load && idle) begin
        if (cfg_bad) begin
          cfg_err <= 1'b1;
        end else begin
          row_elems_q <= cfg_row_elems;
          rows_q      <= cfg_rows;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_addr_q <= '0;
      row_idx_q  <= '0;
    end else if (pop) begin
      if (row_last) begin
        seg_addr_q <= '0;
        row_idx_q  <= tile_last ? '0 : row_idx_q + ROW_CW'(1);
      end else begin
        seg_addr_q <= seg_addr_q + SEG_AW'(1);
      end
    end
  end

  always_comb begin
    sb_d           = '0;
    sb_d.seg_addr  = seg_addr_q;
    sb_d.seg_elems = cur_len;
    sb_d.row_idx   = row_idx_q;
    sb_d.row_last  = row_last;
    sb_d.tile_last = tile_last;
  end

`ifdef REPACK_ZERO_PAD_EN
  assign data_d = head & ~({WORD_W{1'b1}} << (32'(cur_len) * ELEM_W));
`else
  assign data_d = head;
`endif

  // Output register only advances on pop, so a stalled segment holds every out_* field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_q    <= '0;
      sb_q      <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      data_q    <= data_d;
      sb_q      <= sb_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_data      = data_q;
  assign out_seg_addr  = sb_q.seg_addr;
  assign out_seg_elems = sb_q.seg_elems;
  assign out_row_idx   = sb_q.row_idx;
  assign out_row_last  = sb_q.row_last;
  assign out_tile_last = sb_q.tile_last;

endmodule

// File: tb/tb_ifmap_row_repacker.sv
// Directed bench for ifmap_row_repacker: byte-ramp stream in, segments checked against a row/tile model.
module tb_ifmap_row_repacker;
  import ifmap_repack_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cfg_load;
  logic [ROWEL_W-1:0]  cfg_row_elems;
  logic [ROW_CW-1:0]   cfg_rows;
  logic                cfg_err;
  logic                in_valid;
  logic                in_ready;
  logic [WORD_W-1:0]   in_data;
  logic                out_valid;
  logic                out_ready;
  logic [WORD_W-1:0]   out_data;
  logic [SEG_AW-1:0]   out_seg_addr;
  logic [SEGLEN_W-1:0] out_seg_elems;
  logic [ROW_CW-1:0]   out_row_idx;
  logic                out_row_last;
  logic                out_tile_last;

  int vec_cnt = 0;
  int err_cnt = 0;
  int in_byte, exp_byte;
  int m_seg, m_row, m_row_elems, m_rows;
  int words_left, consumed;
  int six_cnt, first_tl, tl_cnt, span_first, span_last;

  ifmap_row_repacker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_load      (cfg_load),
    .cfg_row_elems (cfg_row_elems),
    .cfg_rows      (cfg_rows),
    .cfg_err       (cfg_err),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_seg_addr  (out_seg_addr),
    .out_seg_elems (out_seg_elems),
    .out_row_idx   (out_row_idx),
    .out_row_last  (out_row_last),
    .out_tile_last (out_tile_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] mk_word(input int b);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < IN_ELEMS; i++) w[i*ELEM_W +: ELEM_W] = ELEM_W'(b + i);
    return w;
  endfunction

  task automatic model_reset(input int re, input int rows);
    m_seg = 0; m_row = 0; m_row_elems = re; m_rows = rows; exp_byte = in_byte;
  endtask

  // Compare the presented segment with the model; advance the model when it is consumed.
  task automatic check_seg(input bit advance);
    int rem, e;
    bit rl, tl;
    logic [WORD_W-1:0] ew, mk;
    rem = m_row_elems - m_seg * IN_ELEMS;
    e   = (rem >= IN_ELEMS) ? IN_ELEMS : rem;
    rl  = (rem <= IN_ELEMS);
    tl  = rl && (m_row == m_rows - 1);
    ew = '0; mk = '0;
    for (int i = 0; i < e; i++) begin
      ew[i*ELEM_W +: ELEM_W] = ELEM_W'(exp_byte + i);
      mk[i*ELEM_W +: ELEM_W] = '1;
    end
    chk("seg_elems", 64'(out_seg_elems), 64'(e));
    chk("seg_addr",  64'(out_seg_addr),  64'(m_seg));
    chk("row_idx",   64'(out_row_idx),   64'(m_row));
    chk("row_last",  64'(out_row_last),  64'(rl));
    chk("tile_last", 64'(out_tile_last), 64'(tl));
    chk("data",      64'(out_data & mk), 64'(ew));
    if (advance) begin
      exp_byte += e;
      if (rl) begin
        m_seg = 0;
        m_row = tl ? 0 : m_row + 1;
      end else begin
        m_seg++;
      end
    end
  endtask

  task automatic do_cfg(input int re, input int rows, input bit exp_err);
    cfg_load = 1'b1; cfg_row_elems = ROWEL_W'(re); cfg_rows = ROW_CW'(rows);
    @(negedge clk);
    cfg_load = 1'b0;
    #1 chk("cfg_err", 64'(cfg_err), 64'(exp_err));
    @(negedge clk);
    #1 chk("cfg_err_pulse", 64'(cfg_err), 64'(0));
    @(negedge clk);
    if (!exp_err) begin m_row_elems = re; m_rows = rows; end
  endtask

  // Stream nwords ramp words until nsegs segments are consumed; optional 5-cycle stall and busy cfg_load.
  task automatic run_stream(input int nwords, input int nsegs, input int stall_at,
                            input int busy_at, input int busy_re, input int budget);
    int cyc = 0;
    int stall_left = 0;
    bit stall_done = 0, busy_done = 0, busy_pend = 0;
    words_left = nwords; consumed = 0; span_first = -1; span_last = -1;
    while (consumed < nsegs && cyc < budget) begin
      #1;
      if (busy_pend) begin
        chk("busy_cfg_err", 64'(cfg_err), 64'(0));
        busy_pend = 0;
      end
      in_valid = (words_left > 0);
      in_data  = mk_word(in_byte);
      cfg_load = 1'b0;
      if (!busy_done && busy_at >= 0 && consumed >= busy_at && out_valid) begin
        cfg_load = 1'b1; cfg_row_elems = ROWEL_W'(busy_re); cfg_rows = ROW_CW'(1);
        busy_done = 1; busy_pend = 1;
      end
      if (!stall_done && stall_left == 0 && stall_at >= 0 && consumed >= stall_at && out_valid)
        stall_left = 5;
      out_ready = (stall_left == 0);
      if (out_valid) begin
        if (span_first < 0) span_first = cyc;
        check_seg(out_ready);
        if (out_ready) begin
          if (out_seg_elems == SEGLEN_W'(6)) six_cnt++;
          if (out_tile_last) begin
            tl_cnt++;
            if (first_tl < 0) first_tl = consumed;
          end
          consumed++;
          span_last = cyc;
        end
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) begin
          stall_done = 1;
          chk("stall_in_ready", 64'(in_ready), 64'(0));
        end
      end
      if (in_valid && in_ready) begin
        in_byte += IN_ELEMS;
        words_left--;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; cfg_load = 1'b0; out_ready = 1'b1;
    chk("segs_done", 64'(consumed), 64'(nsegs));
    if (stall_at >= 0) chk("stall_seen", 64'(stall_done), 64'(1));
    if (busy_at >= 0)  chk("busy_seen",  64'(busy_done),  64'(1));
  endtask

  initial begin
    rst_n = 1'b0; cfg_load = 1'b0; cfg_row_elems = '0; cfg_rows = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_byte = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_cfg_err",   64'(cfg_err),   64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_out_data",  64'(out_data),  64'(0));
    chk("rst_seg_addr",  64'(out_seg_addr),  64'(0));
    chk("rst_seg_elems", 64'(out_seg_elems), 64'(0));
    chk("rst_row_idx",   64'(out_row_idx),   64'(0));
    chk("rst_row_last",  64'(out_row_last),  64'(0));
    chk("rst_tile_last", 64'(out_tile_last), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Defaults: 16 rows x 30 elements = 60 words, 64 segments.
    model_reset(30, 16);
    six_cnt = 0; tl_cnt = 0; first_tl = -1;
    run_stream(60, 64, -1, -1, 0, 400);
    chk("t1_six_segs", 64'(six_cnt), 64'(16));
    chk("t1_tile_last_idx", 64'(first_tl), 64'(63));
    chk("t1_tile_cnt", 64'(tl_cnt), 64'(1));
    repeat (2) @(negedge clk);

    // Rejected loads leave the defaults in place for the next tile.
    do_cfg(0, 3, 1'b1);
    do_cfg(65, 3, 1'b1);
    do_cfg(8, 0, 1'b1);

    // Stall mid-row plus an ignored legal load while busy.
    run_stream(60, 64, 5, 20, 16, 600);
    repeat (2) @(negedge clk);

    // Word-multiple rows sustain one segment per cycle.
    do_cfg(32, 2, 1'b0);
    run_stream(8, 8, -1, -1, 0, 100);
    chk("t2_span", 64'(span_last - span_first + 1), 64'(8));
    repeat (2) @(negedge clk);

    // Short rows: every segment is 5 elements and ends its row.
    do_cfg(5, 3, 1'b0);
    tl_cnt = 0;
    run_stream(15, 24, -1, 4, 0, 300);
    chk("t4_tiles", 64'(tl_cnt), 64'(8));
    repeat (2) @(negedge clk);

    // Async reset in the middle of a row.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    in_byte = 128;
    model_reset(30, 16);
    run_stream(60, 2, -1, -1, 0, 50);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'(0));
    chk("t6_in_ready",  64'(in_ready),  64'(1));
    chk("t6_seg_addr",  64'(out_seg_addr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_byte = 0;
    model_reset(30, 16);
    run_stream(60, 64, -1, -1, 0, 400);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
